// File: rtl/gen_scheduler.sv
// rtl/gen_scheduler.sv - generation scheduler pacing life_logic over an N-way frame buffer ring
module gen_scheduler #(
  parameter int NUM_BUFS    = 3,
  parameter int SPEED_WIDTH = 4,
  parameter int GEN_WIDTH   = 16,
  localparam int IW         = (NUM_BUFS <= 2) ? 1 : $clog2(NUM_BUFS)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   render_done_in,
  input  logic                   logic_done_in,
  input  logic [SPEED_WIDTH-1:0] speed_in,
  input  logic                   pause_in,
  input  logic                   step_in,
  output logic                   logic_start_out,
  output logic [IW-1:0]          render_buf_out,
  output logic [IW-1:0]          logic_rd_buf_out,
  output logic [IW-1:0]          logic_wr_buf_out,
  output logic                   busy_out,
  output logic [IW:0]            queued_out,
  output logic [GEN_WIDTH-1:0]   gen_count_out
);

  // Ring arithmetic runs two bits wider than an index so D+Q+1 never overflows.
  localparam logic [IW+1:0] NB     = (IW+2)'(NUM_BUFS);
  // A start needs a free slot that is not the displayed buffer.
  localparam logic [IW:0]   Q_FULL = (IW+1)'(NUM_BUFS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_token;
  logic [SPEED_WIDTH-1:0] r_frame_cnt;
  logic [IW-1:0]          r_disp;
  logic [IW:0]            r_queued;
  logic                   r_start;
  logic [IW-1:0]          r_rd_buf;
  logic [IW-1:0]          r_wr_buf;
  logic [GEN_WIDTH-1:0]   r_gen;

  logic                   w_start;
  logic                   w_done_ok;
  logic                   w_token_set;
  logic                   w_swap;
  logic [IW-1:0]          w_disp_nxt;
  logic [IW:0]            w_queued_nxt;
  logic [IW+1:0]          w_rd_sum;
  logic [IW+1:0]          w_wr_sum;

  // Reduce a value below 2*NUM_BUFS into the ring index range.
  function automatic logic [IW-1:0] ring_wrap(input logic [IW+1:0] x);
    logic [IW+1:0] t;
    t = (x >= NB) ? (x - NB) : x;
    return IW'(t);
  endfunction

  // State register: IDLE waits for token and space, RUN has a generation in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: start moves to RUN, a done pulse returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start)       w_state_nxt = S_RUN;
      S_RUN:  if (logic_done_in) w_state_nxt = S_IDLE;
    endcase
  end

  // State decode: start qualification and filtering of stray done pulses.
  always_comb begin
    w_start   = (r_state == S_IDLE) && r_token && (r_queued < Q_FULL);
    w_done_ok = (r_state == S_RUN) && logic_done_in;
  end

  // Pacing and ring next-state: token earning, swap decision and the new D/Q.
  always_comb begin
    w_token_set  = pause_in ? step_in : (render_done_in && (r_frame_cnt == speed_in));
    w_swap       = render_done_in && ((r_queued != '0) || w_done_ok);
    w_disp_nxt   = w_swap ? ring_wrap((IW+2)'(r_disp) + (IW+2)'(1)) : r_disp;
    w_queued_nxt = r_queued + (IW+1)'(w_done_ok) - (IW+1)'(w_swap);
    w_rd_sum     = (IW+2)'(w_disp_nxt) + (IW+2)'(w_queued_nxt);
    w_wr_sum     = w_rd_sum + (IW+2)'(1);
  end

  // Frame counter and single-bit token; a freshly earned token wins over one being spent.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_frame_cnt <= '0;
      r_token     <= 1'b1;
    end else begin
      if (render_done_in && !pause_in) begin
        r_frame_cnt <= (r_frame_cnt == speed_in) ? '0 : r_frame_cnt + SPEED_WIDTH'(1);
      end
      if (w_token_set) begin
        r_token <= 1'b1;
      end else if (w_start) begin
        r_token <= 1'b0;
      end
    end
  end

  // Ring registers plus registered buffer indices derived from the next D and Q.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_disp   <= '0;
      r_queued <= '0;
      r_rd_buf <= '0;
      r_wr_buf <= ring_wrap((IW+2)'(1));
    end else begin
      r_disp   <= w_disp_nxt;
      r_queued <= w_queued_nxt;
      r_rd_buf <= ring_wrap(w_rd_sum);
      r_wr_buf <= ring_wrap(w_wr_sum);
    end
  end

  // Start pulse and completed-generation counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_start <= 1'b0;
      r_gen   <= '0;
    end else begin
      r_start <= w_start;
      if (w_done_ok) begin
        r_gen <= r_gen + GEN_WIDTH'(1);
      end
    end
  end

  assign logic_start_out  = r_start;
  assign busy_out         = (r_state == S_RUN);
  assign render_buf_out   = r_disp;
  assign logic_rd_buf_out = r_rd_buf;
  assign logic_wr_buf_out = r_wr_buf;
  assign queued_out       = r_queued;
  assign gen_count_out    = r_gen;

endmodule

// File: tb/tb_gen_scheduler.sv
// tb/tb_gen_scheduler.sv - self-checking bench for gen_scheduler, 3-buffer and 2-buffer instances
module tb_gen_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdn;
  logic       ldn;
  logic [3:0] speed;
  logic       pause;
  logic       step;

  logic        s3_start, s3_busy;
  logic [1:0]  s3_render, s3_rd, s3_wr;
  logic [2:0]  s3_q;
  logic [15:0] s3_gen;

  logic        s2_start, s2_busy;
  logic [0:0]  s2_render, s2_rd, s2_wr;
  logic [1:0]  s2_q;
  logic [15:0] s2_gen;

  gen_scheduler #(.NUM_BUFS(3), .SPEED_WIDTH(4), .GEN_WIDTH(16)) u3 (
    .clk_in(clk), .rst_in(rst_n), .render_done_in(rdn), .logic_done_in(ldn),
    .speed_in(speed), .pause_in(pause), .step_in(step),
    .logic_start_out(s3_start), .render_buf_out(s3_render), .logic_rd_buf_out(s3_rd),
    .logic_wr_buf_out(s3_wr), .busy_out(s3_busy), .queued_out(s3_q), .gen_count_out(s3_gen)
  );

  gen_scheduler #(.NUM_BUFS(2), .SPEED_WIDTH(4), .GEN_WIDTH(16)) u2 (
    .clk_in(clk), .rst_in(rst_n), .render_done_in(rdn), .logic_done_in(ldn),
    .speed_in(speed), .pause_in(pause), .step_in(step),
    .logic_start_out(s2_start), .render_buf_out(s2_render), .logic_rd_buf_out(s2_rd),
    .logic_wr_buf_out(s2_wr), .busy_out(s2_busy), .queued_out(s2_q), .gen_count_out(s2_gen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int q;
    int busy;
    int token;
    int cnt;
    int gen;
    int start;
  } model_t;

  model_t m3, m2;
  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  int done_at = -1;
  int stray_at = -1;
  int rd_force = -1;
  int rper = 0;
  int rbase = 0;
  int lat = 20;
  int step_q[$];
  int c3, c2;

  function automatic model_t mreset();
    model_t r;
    r.d = 0; r.q = 0; r.busy = 0; r.token = 1; r.cnt = 0; r.gen = 0; r.start = 0;
    return r;
  endfunction

  // One clock of the scheduler rules on an n-buffer ring.
  function automatic model_t mstep(model_t m, int n, logic rd, logic ld, int spd, logic pau, logic stp);
    model_t r = m;
    int done_ok = (ld && m.busy != 0) ? 1 : 0;
    int can_start = (m.token != 0 && m.busy == 0 && m.q < n - 1) ? 1 : 0;
    int earn = pau ? int'(stp) : ((rd && m.cnt == spd) ? 1 : 0);
    r.start = can_start;
    if (can_start != 0) begin r.busy = 1; r.token = 0; end
    if (done_ok != 0) begin r.busy = 0; r.q = r.q + 1; r.gen = (m.gen + 1) % 65536; end
    if (rd && !pau) r.cnt = (m.cnt == spd) ? 0 : m.cnt + 1;
    if (earn != 0) r.token = 1;
    if (rd && (m.q > 0 || done_ok != 0)) begin r.d = (m.d + 1) % n; r.q = r.q - 1; end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, k);
    end
  endtask

  // Per-cycle comparison of both instances against their models.
  always @(negedge clk) begin
    chk("d3 start",  s3_start,  m3.start);
    chk("d3 busy",   s3_busy,   m3.busy);
    chk("d3 render", s3_render, m3.d);
    chk("d3 rd",     s3_rd,     (m3.d + m3.q) % 3);
    chk("d3 wr",     s3_wr,     (m3.d + m3.q + 1) % 3);
    chk("d3 queued", s3_q,      m3.q);
    chk("d3 gen",    s3_gen,    m3.gen);
    chk("d2 start",  s2_start,  m2.start);
    chk("d2 busy",   s2_busy,   m2.busy);
    chk("d2 render", s2_render, m2.d);
    chk("d2 rd",     s2_rd,     (m2.d + m2.q) % 2);
    chk("d2 wr",     s2_wr,     (m2.d + m2.q + 1) % 2);
    chk("d2 queued", s2_q,      m2.q);
    chk("d2 gen",    s2_gen,    m2.gen);
    chk("d2 q_le_1", (s2_q <= 2'd1), 1);
    if (s2_start) chk("d2 wr_ne_render", (s2_wr != s2_render), 1);
  end

  task automatic drive();
    int nk = k + 1;
    rdn  = ((rper > 0 && nk > rbase && (nk - rbase) % rper == 0) || nk == rd_force);
    ldn  = (nk == done_at || nk == stray_at);
    step = 1'b0;
    foreach (step_q[i]) if (step_q[i] == nk) step = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m3 = mreset();
      m2 = mreset();
    end else begin
      m3 = mstep(m3, 3, rdn, ldn, int'(speed), pause, step);
      m2 = mstep(m2, 2, rdn, ldn, int'(speed), pause, step);
    end
    k++;
    if (m3.start != 0) done_at = k + lat;
    @(negedge clk);
  endtask

  task automatic run_to(input int t);
    while (k < t) begin
      drive();
      tick();
    end
  endtask

  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    m3 = mreset(); m2 = mreset();
    done_at = -1; stray_at = -1; rd_force = -1; rper = 0;
    step_q.delete();
    rdn = 1'b0; ldn = 1'b0; step = 1'b0;
  endtask

  task automatic release_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    k = 0;
  endtask

  initial begin
    m3 = mreset(); m2 = mreset();
    rdn = 1'b0; ldn = 1'b0; speed = 4'd0; pause = 1'b0; step = 1'b0;
    @(negedge clk);
    assert_reset();
    release_reset();

    // Reset release, speed 0, logic 20 cycles, frames every 100.
    chk("A reset wr", s3_wr, 1);
    chk("A reset rd", s3_rd, 0);
    lat = 20; rper = 100; rbase = 0;
    run_to(1);
    chk("A first start", s3_start, 1);
    chk("A first wr", s3_wr, 1);
    run_to(21);
    chk("A q after done", s3_q, 1);
    chk("A rd after done", s3_rd, 1);
    chk("A wr after done", s3_wr, 2);
    run_to(100);
    chk("A swap render", s3_render, 1);
    chk("A swap q", s3_q, 0);
    run_to(121);
    chk("A wrap wr", s3_wr, 0);
    chk("A wrap rd", s3_rd, 2);
    chk("A gen", s3_gen, 2);
    run_to(150);

    // Paused: steps fill the ring to Q=2 and stall until a frame frees a slot.
    pause = 1'b1; rper = 0;
    step_q = '{160, 200, 250};
    rd_force = 220;
    run_to(181);
    chk("B q full", s3_q, 2);
    chk("B gen", s3_gen, 3);
    chk("B full rd", s3_rd, 0);
    run_to(210);
    chk("B stalled busy", s3_busy, 0);
    run_to(221);
    chk("B restart", s3_start, 1);
    chk("B restart render", s3_render, 2);
    chk("B restart wr", s3_wr, 1);
    run_to(260);

    // Render done coincident with logic done at Q=0.
    pause = 1'b0; speed = 4'd0;
    assert_reset();
    release_reset();
    lat = 10; rd_force = 11;
    run_to(11);
    chk("C render", s3_render, 1);
    chk("C q", s3_q, 0);
    chk("C gen", s3_gen, 1);
    chk("C n2 render", s2_render, 1);
    chk("C n2 q", s2_q, 0);

    // speed 3: one start per four frames.
    speed = 4'd3; lat = 2; rper = 10; rbase = k; rd_force = -1;
    c3 = 0; c2 = 0;
    repeat (400) begin
      drive();
      tick();
      if (s3_start) c3++;
      if (s2_start) c2++;
    end
    chk("E starts n3", c3, 10);
    chk("E starts n2", c2, 10);
    chk("E gen n3", s3_gen, 11);
    chk("E gen n2", s2_gen, 11);

    // Reset mid-generation, then a stray done right after release.
    speed = 4'd0; lat = 50;
    assert_reset();
    release_reset();
    run_to(5);
    chk("D busy before", s3_busy, 1);
    assert_reset();
    #1;
    chk("D async busy", s3_busy, 0);
    chk("D async wr", s3_wr, 1);
    chk("D async n2 busy", s2_busy, 0);
    release_reset();
    stray_at = 1;
    run_to(1);
    chk("D stray gen", s3_gen, 0);
    chk("D stray q", s3_q, 0);
    run_to(10);
    chk("D late gen", s3_gen, 0);
    chk("D late n2 gen", s2_gen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
